// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// controller state encodings and the divide-by-zero quotient pattern.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 6;

    localparam logic [WIDTH_DEF-1:0] Q_ALL_ONES = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LDQ   = 3'd1;
    localparam logic [2:0] S_LDM   = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_OUT_R = 3'd4;
    localparam logic [2:0] S_OUT_Q = 3'd5;

endpackage

// File: rtl/seq_divider_datapath.sv
// A/Q/M registers of the restoring divider: one shift-subtract-restore step per
// iter cycle, plus zero-divisor detect and the sticky divide-by-zero flag.
module seq_divider_datapath
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_q,
    input  logic             ld_m,
    input  logic             iter,
    input  logic             clr_flag,
    input  logic [WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quo,
    output logic             div_zero,
    output logic             dbz_flag
);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH+1:0] a_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    // Shifted A carries the top dividend bit; trial sign decides restore.
    assign a_sh      = {a, q[WIDTH-1]};
    assign trial     = a_sh - {2'b00, m};
    assign trial_neg = trial[WIDTH+1];
    assign div_zero  = (in_bus == '0);
    assign rem       = a[WIDTH-1:0];
    assign quo       = q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            q        <= '0;
            m        <= '0;
            dbz_flag <= 1'b0;
        end else begin
            if (clr_flag) begin
                dbz_flag <= 1'b0;
            end
            if (ld_q) begin
                q <= in_bus;
                a <= '0;
            end
            if (ld_m) begin
                m <= in_bus;
                if (div_zero) begin
                    a        <= {1'b0, q};
                    q        <= '1;
                    dbz_flag <= 1'b1;
                end
            end
            if (iter) begin
                a <= trial_neg ? a_sh[WIDTH:0] : trial[WIDTH:0];
                q <= {q[WIDTH-2:0], ~trial_neg};
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: controller FSM and iteration counter
// around the datapath; remainder then quotient on outBus on consecutive cycles.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inBus,
    output logic [WIDTH-1:0] outBus,
    output logic             ready,
    output logic             done,
    output logic             remSel,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             div_zero;
    logic             accept;

    assign accept = (state == S_IDLE) && start;

    seq_divider_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .ld_q     (state == S_LDQ),
        .ld_m     (state == S_LDM),
        .iter     (state == S_ITER),
        .clr_flag (accept),
        .in_bus   (inBus),
        .rem      (rem),
        .quo      (quo),
        .div_zero (div_zero),
        .dbz_flag (divByZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_LDQ;
                S_LDQ:   state <= S_LDM;
                S_LDM: begin
                    cnt   <= CW'(WIDTH);
                    state <= div_zero ? S_OUT_R : S_ITER;
                end
                S_ITER: begin
                    cnt <= cnt - 1'b1;
                    // Last iteration when the count is about to hit zero.
                    if (cnt == CW'(1)) state <= S_OUT_R;
                end
                S_OUT_R: state <= S_OUT_Q;
                S_OUT_Q: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready  = (state == S_IDLE);
        done   = (state == S_OUT_R) || (state == S_OUT_Q);
        remSel = (state == S_OUT_R);
        outBus = '0;
        if (state == S_OUT_R) outBus = rem;
        else if (state == S_OUT_Q) outBus = quo;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results, a
// monitor checks remainder/quotient phases and their cycle timing.
module tb_seq_divider;
    import seq_divider_pkg::*;

    typedef struct {
        logic [5:0] r;
        logic [5:0] q;
        logic       z;
        int         rc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] inBus;
    logic [5:0] outBus;
    logic       ready;
    logic       done;
    logic       remSel;
    logic       divByZero;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_q_cyc = -100;
    exp_t sbq[$];

    seq_divider #(.WIDTH(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inBus     (inBus),
        .outBus    (outBus),
        .ready     (ready),
        .done      (done),
        .remSel    (remSel),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One operation. poke_at / rst_at are offsets from the start cycle (0 = unused).
    task automatic run_div(input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] er, input logic [5:0] eq,
                           input bit push, input int poke_at, input int rst_at,
                           input bit b2b);
        int   n;
        int   k;
        exp_t e;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        k = cyc;
        if (b2b) chk("b2b_start", k, last_q_cyc + 1);
        start = 1'b1;
        if (push) begin
            e.r  = er;
            e.q  = eq;
            e.z  = (b == 0);
            e.rc = k + ((b == 0) ? 3 : 9);
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        inBus = a;
        chk("dbz_cleared_on_start", divByZero, 0);
        @(negedge clk);
        inBus = b;
        @(negedge clk);
        inBus = 6'($urandom);
        if (poke_at != 0) begin
            while (cyc < k + poke_at) @(negedge clk);
            start = 1'b1;
            inBus = 6'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        if (rst_at != 0) begin
            while (cyc < k + rst_at) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_ready", ready, 1);
            chk("midrst_done", done, 0);
            chk("midrst_remsel", remSel, 0);
            chk("midrst_outbus", outBus, 0);
            chk("midrst_dbz", divByZero, 0);
            rst = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rem_cycle", cyc, e.rc);
                    chk("rem_sel", remSel, 1);
                    chk("remainder", outBus, e.r);
                    chk("dbz_rem_phase", divByZero, e.z);
                    @(negedge clk);
                    chk("quo_done", done, 1);
                    chk("quo_sel", remSel, 0);
                    chk("quotient", outBus, e.q);
                    last_q_cyc = cyc;
                    @(negedge clk);
                    chk("idle_ready", ready, 1);
                    chk("idle_done", done, 0);
                    chk("dbz_idle", divByZero, e.z);
                end
            end else begin
                chk("idle_outbus_zero", outBus, 0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst   = 1'b1;
        start = 1'b0;
        inBus = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_remsel", remSel, 0);
        chk("reset_outbus", outBus, 0);
        chk("reset_dbz", divByZero, 0);
        rst = 1'b0;
        @(negedge clk);

        run_div(6'd45, 6'd7,  6'd3,  6'd6,  1, 0, 0, 0);
        run_div(6'd63, 6'd1,  6'd0,  6'd63, 1, 0, 0, 1);
        run_div(6'd5,  6'd9,  6'd5,  6'd0,  1, 0, 0, 1);
        run_div(6'd20, 6'd0,  6'd20, Q_ALL_ONES, 1, 0, 0, 1);
        run_div(6'd45, 6'd7,  6'd3,  6'd6,  1, 4, 0, 1);
        run_div(6'd60, 6'd8,  6'd4,  6'd7,  1, 0, 0, 1);
        run_div(6'd33, 6'd5,  6'd0,  6'd0,  0, 0, 5, 0);
        run_div(6'd12, 6'd4,  6'd0,  6'd3,  1, 0, 0, 0);

        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                if (b == 0)
                    run_div(6'(a), 6'(b), 6'(a), 6'h3f, 1, 0, 0, 0);
                else
                    run_div(6'(a), 6'(b), 6'(a % b), 6'(a / b), 1, 0, 0, 0);
            end
        end

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider with built-in controller; one quotient bit per cycle.
- Companion to the Booth multiplier: same shared 6-bit operand bus in, same 6-bit result bus out, result delivered as two halves on consecutive cycles.
- Sits beside the multiplier on inBus/outBus and is driven by the same host sequencer.

Parameters:
- WIDTH, 6, operand/quotient/remainder width; counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- inBus  input  WIDTH  operand bus: dividend in the 1st cycle after start, divisor in the 2nd.
- outBus  output  WIDTH  remainder during OUT_R, quotient during OUT_Q, 0 otherwise.
- ready  output  1  high in IDLE only.
- done  output  1  high during OUT_R and OUT_Q.
- remSel  output  1  1 while outBus carries the remainder (OUT_R), else 0.
- divByZero  output  1  set when the latched divisor is 0; held until the next accepted start or reset.

Behaviour:
- Reset (rst=1 at a clock edge) from any state, including mid-operation:
  - state=IDLE; A, Q, M and counter cleared; divByZero=0.
  - Outputs after reset: ready=1, done=0, remSel=0, outBus=0.
- States: IDLE, LDQ, LDM, ITER, OUT_R, OUT_Q.
- IDLE: start=1 -> LDQ, and divByZero is cleared. start=0 -> stay.
- LDQ (1 cycle): Q<=inBus, A<=0 -> LDM.
- LDM (1 cycle): M<=inBus, counter<=WIDTH.
  - inBus==0 -> A<=Q (remainder = dividend), Q<=all ones, divByZero<=1, next state OUT_R (ITER skipped).
  - Otherwise -> ITER.
- ITER, one iteration per cycle:
  - {A,Q} shifted left 1; A is WIDTH+1 bits internally.
  - trial = shifted A - M, computed in WIDTH+2 bits.
  - trial >= 0: A<=trial, Q[0]<=1. Otherwise: A<=shifted A (restore), Q[0]<=0.
  - counter decrements; when counter reaches 0 after the update (WIDTH cycles total) -> OUT_R.
- OUT_R (1 cycle): outBus=A[WIDTH-1:0], done=1, remSel=1 -> OUT_Q.
- OUT_Q (1 cycle): outBus=Q, done=1, remSel=0 -> IDLE.
- Timing: start high in cycle k; dividend on inBus in k+1; divisor in k+2; ITER k+3..k+8; remainder at k+9; quotient at k+10; ready=1 at k+11. Divide-by-zero: remainder at k+3, quotient at k+4.
- start outside IDLE is ignored; inBus is ignored except in LDQ and LDM.
- Back-to-back: start in the first IDLE cycle after OUT_R/OUT_Q is accepted; no dead cycle.
- outBus is always driven (no tristate); the host muxes it against the multiplier using done.
- All outputs are decoded combinationally from registered state and registers; no combinational path from inBus to outBus.

Decomposition:
- Shared package: state enum (IDLE, LDQ, LDM, ITER, OUT_R, OUT_Q), WIDTH default constant, all-ones quotient constant for divide-by-zero.
- One natural sub-module: seq_divider_datapath. It holds the A/Q/M registers, shift and subtract/restore logic, and the zero-divisor detect. The FSM and counter stay in the top level, matching the split between the multiplier's datapath and controller.

Test Plan:
- 45/7: start, inBus 45 then 7 -> at k+9 outBus=3, remSel=1, done=1; at k+10 outBus=6, remSel=0; divByZero=0.
- 63/1 and 5/9 -> R=0, Q=63; then R=5, Q=0 (checks all-ones quotient and zero quotient).
- 20/0 -> at k+3 outBus=20, remSel=1, divByZero=1; at k+4 outBus=63; divByZero still 1 in IDLE; cleared on the next start.
- rst=1 at k+5 (mid-ITER) -> next cycle ready=1, done=0, outBus=0; a fresh 12/4 then returns R=0, Q=3 with nominal timing.
- start pulsed at k+4 during ITER ignored -> the 45/7 result is unchanged. Back-to-back: start at k+11 with 60/8 -> R=4, Q=7 at k+20/k+21.
- Random sweep of all 64x64 operand pairs -> Q==a/b and R==a%b for b!=0; b==0 case as above.
